// File: rtl/haar_params_pkg.sv
// haar_params_pkg: store layout constants, pass states and address helper shared by loader, reader and evaluator
package haar_params_pkg;
  localparam int NPPC = 19;
  localparam int NST = 3;
  typedef enum logic [2:0] {
    IDLE,
    FETCH_CLS,
    PRESENT_CLS,
    FETCH_THR,
    PRESENT_THR
  } state_t;
  function automatic int unsigned param_addr(input int unsigned k, input int unsigned p, input int unsigned nppc);
    return k * nppc + p;
  endfunction
endpackage

// File: rtl/haar_record_assembler.sv
// haar_record_assembler: walks len consecutive store addresses and strobes each byte slot as its data returns
module haar_record_assembler #(
  parameter int ADDR_WIDTH = 10,
  parameter int CW = 5
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  load,
  input  logic                  kill,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CW-1:0]         len,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  wr_en,
  output logic [CW-1:0]         wr_slot,
  output logic                  wr_last
);
  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_q;
  // one address per cycle; the slot strobe trails its address by a cycle to line up with mem_q
  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      active      <= 1'b0;
      cnt         <= '0;
      len_q       <= '0;
      mem_address <= '0;
      wr_en       <= 1'b0;
      wr_slot     <= '0;
      wr_last     <= 1'b0;
    end else begin
      wr_en   <= active && !kill;
      wr_slot <= cnt;
      wr_last <= active && !kill && cnt == len_q - CW'(1);
      if (kill) active <= 1'b0;
      else if (load) begin
        mem_address <= base;
        cnt         <= '0;
        len_q       <= len;
        active      <= 1'b1;
      end else if (active && cnt == len_q - CW'(1)) active <= 1'b0;
      else if (active) begin
        mem_address <= mem_address + ADDR_WIDTH'(1);
        cnt         <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/haar_stage_param_reader.sv
// haar_stage_param_reader: streams one stage's classifier records and threshold record out of the parameter store
module haar_stage_param_reader
  import haar_params_pkg::*;
#(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH_8             = 8,
  parameter int NUM_CLASSIFIERS          = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = NPPC,
  parameter int NUM_STAGE_THRESHOLD      = NST,
  parameter int INDEX_WIDTH              = 8
) (
  input  logic                                           clk_fpga,
  input  logic                                           reset_fpga,
  input  logic                                           store_ready,
  input  logic                                           start,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           abort,
  output logic [ADDR_WIDTH-1:0]                          mem_address,
  input  logic [DATA_WIDTH_8-1:0]                        mem_q,
  output logic                                           cls_valid,
  input  logic                                           cls_ready,
  output logic [DATA_WIDTH_8*NUM_PARAM_PER_CLASSIFIER-1:0] cls_data,
  output logic [INDEX_WIDTH-1:0]                         cls_index,
  output logic                                           cls_last,
  output logic                                           thr_valid,
  input  logic                                           thr_ready,
  output logic [DATA_WIDTH_8*NUM_STAGE_THRESHOLD-1:0]    thr_data
);
  localparam int MAXN = NUM_PARAM_PER_CLASSIFIER > NUM_STAGE_THRESHOLD ? NUM_PARAM_PER_CLASSIFIER : NUM_STAGE_THRESHOLD;
  localparam int CW = $clog2(MAXN + 1);
  state_t                state;
  logic                  kill;
  logic                  start_ok;
  logic                  cls_hs;
  logic                  load;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0]         len;
  logic                  wr_en;
  logic                  wr_last;
  logic [CW-1:0]         wr_slot;
  // next fetch request: a fresh pass starts at 0, otherwise the record after the one just handed off
  always_comb begin
    kill     = state != IDLE && !store_ready;
    start_ok = state == IDLE && start && store_ready;
    cls_hs   = state == PRESENT_CLS && cls_ready;
    load     = !kill && (start_ok || cls_hs);
    base     = start_ok ? '0 :
               cls_last ? ADDR_WIDTH'(param_addr(NUM_CLASSIFIERS, 0, NUM_PARAM_PER_CLASSIFIER)) :
                          ADDR_WIDTH'(param_addr(32'(cls_index) + 1, 0, NUM_PARAM_PER_CLASSIFIER));
    len      = cls_hs && cls_last ? CW'(NUM_STAGE_THRESHOLD) : CW'(NUM_PARAM_PER_CLASSIFIER);
  end
  haar_record_assembler #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CW        (CW)
  ) u_asm (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .load       (load),
    .kill       (kill),
    .base       (base),
    .len        (len),
    .mem_address(mem_address),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_last    (wr_last)
  );
  // pass sequencer: owns the state, record registers and handshake outputs; a store_ready drop wins over everything
  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      cls_valid <= 1'b0;
      thr_valid <= 1'b0;
      cls_data  <= '0;
      thr_data  <= '0;
      cls_index <= '0;
      cls_last  <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (wr_en && state == FETCH_CLS) cls_data[DATA_WIDTH_8*wr_slot +: DATA_WIDTH_8] <= mem_q;
      if (wr_en && state == FETCH_THR) thr_data[DATA_WIDTH_8*wr_slot +: DATA_WIDTH_8] <= mem_q;
      if (kill) begin
        state     <= IDLE;
        busy      <= 1'b0;
        cls_valid <= 1'b0;
        thr_valid <= 1'b0;
        abort     <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start_ok) begin
            state     <= FETCH_CLS;
            busy      <= 1'b1;
            cls_index <= '0;
            cls_last  <= NUM_CLASSIFIERS == 1;
          end
          FETCH_CLS: if (wr_en && wr_last) begin
            state     <= PRESENT_CLS;
            cls_valid <= 1'b1;
          end
          PRESENT_CLS: if (cls_ready) begin
            cls_valid <= 1'b0;
            state     <= cls_last ? FETCH_THR : FETCH_CLS;
            if (!cls_last) begin
              cls_index <= cls_index + INDEX_WIDTH'(1);
              cls_last  <= cls_index == INDEX_WIDTH'(NUM_CLASSIFIERS - 2);
            end
          end
          FETCH_THR: if (wr_en && wr_last) begin
            state     <= PRESENT_THR;
            thr_valid <= 1'b1;
          end
          PRESENT_THR: if (thr_ready) begin
            thr_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_haar_stage_param_reader.sv
// tb_haar_stage_param_reader: table-driven and randomized checks of record streaming against a store-layout model
module tb_haar_stage_param_reader;
  localparam int NC = 10;
  localparam int NPPC = 19;
  localparam int NST = 3;

  logic         clk;
  logic         reset_fpga;
  logic         store_ready;
  logic         start, start2;
  logic         busy, done, abort, busy2, done2, abort2;
  logic [9:0]   mem_address, mem_address2;
  logic [7:0]   mem_q, mem_q2;
  logic         cls_valid, cls_ready, cls_last, cls_valid2, cls_ready2, cls_last2;
  logic [151:0] cls_data;
  logic [15:0]  cls_data2;
  logic [7:0]   cls_index, cls_index2;
  logic         thr_valid, thr_ready, thr_valid2, thr_ready2;
  logic [23:0]  thr_data;
  logic [7:0]   thr_data2;
  logic [7:0]   mem [1024];

  haar_stage_param_reader dut (
    .clk_fpga(clk), .reset_fpga(reset_fpga), .store_ready(store_ready), .start(start),
    .busy(busy), .done(done), .abort(abort), .mem_address(mem_address), .mem_q(mem_q),
    .cls_valid(cls_valid), .cls_ready(cls_ready), .cls_data(cls_data), .cls_index(cls_index),
    .cls_last(cls_last), .thr_valid(thr_valid), .thr_ready(thr_ready), .thr_data(thr_data)
  );

  haar_stage_param_reader #(
    .NUM_CLASSIFIERS(1), .NUM_PARAM_PER_CLASSIFIER(2), .NUM_STAGE_THRESHOLD(1)
  ) dut2 (
    .clk_fpga(clk), .reset_fpga(reset_fpga), .store_ready(store_ready), .start(start2),
    .busy(busy2), .done(done2), .abort(abort2), .mem_address(mem_address2), .mem_q(mem_q2),
    .cls_valid(cls_valid2), .cls_ready(cls_ready2), .cls_data(cls_data2), .cls_index(cls_index2),
    .cls_last(cls_last2), .thr_valid(thr_valid2), .thr_ready(thr_ready2), .thr_data(thr_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read store: data appears the cycle after its address
  always @(posedge clk) begin
    mem_q  <= mem[mem_address];
    mem_q2 <= mem[mem_address2];
  end

  typedef struct {
    int stall_k;
    int stall_n;
    int thr_stall;
    int exp_done;
  } vec_t;
  vec_t tbl[5];

  int passed, total;
  int cyc, t0;
  int rec_cnt, thr_cnt, done_cnt, abort_cnt, first_v, done_cyc, wait_c, thr_wait;
  int stall_k, stall_n, thr_stall;
  bit rand_mode;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [151:0] exp_cls(input int k);
    logic [151:0] r;
    r = '0;
    for (int p = 0; p < NPPC; p++) r[8*p +: 8] = mem[k*NPPC + p];
    return r;
  endfunction

  function automatic logic [23:0] exp_thr();
    logic [23:0] r;
    for (int t = 0; t < NST; t++) r[8*t +: 8] = mem[NC*NPPC + t];
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 160'(busy), 160'(0));
    chk({tag, "_done"}, 160'(done), 160'(0));
    chk({tag, "_abort"}, 160'(abort), 160'(0));
    chk({tag, "_cls_valid"}, 160'(cls_valid), 160'(0));
    chk({tag, "_thr_valid"}, 160'(thr_valid), 160'(0));
    chk({tag, "_mem_address"}, 160'(mem_address), 160'(0));
    chk({tag, "_cls_data"}, 160'(cls_data), 160'(0));
    chk({tag, "_thr_data"}, 160'(thr_data), 160'(0));
    chk({tag, "_cls_index"}, 160'(cls_index), 160'(0));
    chk({tag, "_cls_last"}, 160'(cls_last), 160'(0));
  endtask

  // one cycle: drive the evaluator side, then score whatever the reader presents
  task automatic tick();
    int rel;
    @(negedge clk);
    cyc++;
    rel = cyc - t0;
    chk("both_valid", 160'(cls_valid & thr_valid), 160'(0));
    if (rand_mode) begin
      cls_ready = 1'($urandom_range(0, 1));
      thr_ready = 1'($urandom_range(0, 1));
    end else begin
      cls_ready = !(cls_valid && int'(cls_index) == stall_k && wait_c < stall_n);
      if (!cls_ready) wait_c++;
      thr_ready = !(thr_valid && thr_wait < thr_stall);
      if (!thr_ready) thr_wait++;
    end
    if (cls_valid) begin
      if (first_v < 0) first_v = rel;
      chk("cls_index", 160'(cls_index), 160'(rec_cnt));
      chk("cls_last", 160'(cls_last), 160'(rec_cnt == NC - 1));
      chk("cls_data", 160'(cls_data), 160'(exp_cls(rec_cnt)));
      chk("addr_frozen", 160'(mem_address), 160'(rec_cnt*NPPC + NPPC - 1));
      if (cls_ready) rec_cnt++;
    end
    if (thr_valid) begin
      chk("thr_data", 160'(thr_data), 160'(exp_thr()));
      chk("thr_after_all", 160'(rec_cnt), 160'(NC));
      if (thr_ready) thr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = rel;
      chk("busy_at_done", 160'(busy), 160'(0));
    end
    if (abort) abort_cnt++;
  endtask

  task automatic start_pass();
    rec_cnt = 0; thr_cnt = 0; done_cnt = 0; abort_cnt = 0;
    first_v = -1; done_cyc = -1; wait_c = 0; thr_wait = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      tick();
      start = (cyc - t0 == 49);
    end
    start = 1'b0;
    chk("done_seen", 160'(done_cnt > 0), 160'(1));
    repeat (3) tick();
    chk("done_once", 160'(done_cnt), 160'(1));
    chk("no_abort", 160'(abort_cnt), 160'(0));
    chk("thr_once", 160'(thr_cnt), 160'(1));
  endtask

  initial begin
    int a0, v2, tv2, d2;
    tbl[0] = '{0, 0, 0, 216};
    tbl[1] = '{3, 5, 0, 221};
    tbl[2] = '{9, 2, 4, 222};
    tbl[3] = '{0, 7, 0, 223};
    tbl[4] = '{5, 1, 1, 218};
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    passed = 0; total = 0; cyc = 0; t0 = 0;
    rand_mode = 0; stall_k = 0; stall_n = 0; thr_stall = 0;
    rec_cnt = 0; thr_cnt = 0; done_cnt = 0; abort_cnt = 0; first_v = -1; wait_c = 0; thr_wait = 0;
    reset_fpga = 1'b0; store_ready = 1'b1; start = 1'b0; start2 = 1'b0;
    cls_ready = 1'b1; thr_ready = 1'b1; cls_ready2 = 1'b1; thr_ready2 = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    reset_fpga = 1'b1;
    tick();

    // start without a loaded store is ignored
    store_ready = 1'b0;
    a0 = int'(mem_address);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("nostore_busy", 160'(busy), 160'(0));
    chk("nostore_addr", 160'(mem_address), 160'(a0));
    store_ready = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      stall_k = tbl[v].stall_k;
      stall_n = tbl[v].stall_n;
      thr_stall = tbl[v].thr_stall;
      start_pass();
      chk("busy_cycle1", 160'(busy), 160'(1));
      chk("addr_cycle1", 160'(mem_address), 160'(0));
      wait_done();
      chk("first_valid_cycle", 160'(first_v), 160'(21));
      chk("done_cycle", 160'(done_cyc), 160'(tbl[v].exp_done));
      chk("rec_count", 160'(rec_cnt), 160'(NC));
    end

    // store_ready drops while record 4 is being fetched
    stall_n = 0; thr_stall = 0;
    start_pass();
    for (int i = 0; i < 200 && cyc - t0 < 90; i++) tick();
    chk("abort_at_rec4", 160'(rec_cnt), 160'(4));
    store_ready = 1'b0;
    tick();
    chk("abort_pulse", 160'(abort), 160'(1));
    chk("abort_busy", 160'(busy), 160'(0));
    chk("abort_cls_valid", 160'(cls_valid), 160'(0));
    store_ready = 1'b1;
    tick();
    chk("abort_one_cycle", 160'(abort), 160'(0));
    repeat (3) tick();
    chk("abort_no_done", 160'(done_cnt), 160'(0));
    chk("abort_count", 160'(abort_cnt), 160'(1));
    start_pass();
    wait_done();
    chk("restart_done_cycle", 160'(done_cyc), 160'(216));

    // randomized store contents and evaluator back-pressure
    rand_mode = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      start_pass();
      wait_done();
      chk("rand_rec_count", 160'(rec_cnt), 160'(NC));
    end
    rand_mode = 0;

    // reset while the threshold record waits
    thr_stall = 100000;
    start_pass();
    for (int i = 0; i < 400 && !thr_valid; i++) tick();
    chk("thr_reached", 160'(thr_valid), 160'(1));
    reset_fpga = 1'b0;
    tick();
    check_reset("midrst");
    reset_fpga = 1'b1;
    thr_stall = 0;
    tick();
    chk("midrst_no_done", 160'(done_cnt), 160'(0));
    chk("midrst_done_low", 160'(done), 160'(0));

    // minimal geometry: one 2-byte classifier, one threshold byte
    v2 = -1; tv2 = -1; d2 = -1;
    start2 = 1'b1;
    t0 = cyc;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cls_valid2 && v2 < 0) begin
        v2 = cyc - t0;
        chk("small_last", 160'(cls_last2), 160'(1));
        chk("small_index", 160'(cls_index2), 160'(0));
        chk("small_data", 160'(cls_data2), 160'({mem[1], mem[0]}));
      end
      if (thr_valid2 && tv2 < 0) begin
        tv2 = cyc - t0;
        chk("small_thr", 160'(thr_data2), 160'(mem[2]));
      end
      if (done2) d2 = cyc - t0;
    end
    chk("small_cls_cycle", 160'(v2), 160'(4));
    chk("small_thr_cycle", 160'(tv2), 160'(7));
    chk("small_done_cycle", 160'(d2), 160'(8));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
